rr_mux_n_1: RTL and testbench



---
 rtl/rr_mux_n_1.sv | 115 +++++++++++
 tb/tb_rr_mux_n_1.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/rr_mux_n_1.sv
// N:1 round-robin multiplexer with per-channel valid/ready and a registered output stage.
// Optional packet lock (grant held until in_last) is enabled by defining RR_MUX_PKT_LOCK_EN.
module rr_mux_n_1 #(
  parameter int XLEN = 32,
  parameter int N    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N*XLEN-1:0]         in_data,
  input  logic [N-1:0]              in_valid,
`ifdef RR_MUX_PKT_LOCK_EN
  input  logic [N-1:0]              in_last,
`endif
  output logic [N-1:0]              in_ready,
  output logic [XLEN-1:0]           out_data,
  output logic [$clog2(N)-1:0]      out_sel,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int SELW = $clog2(N);

  logic [SELW-1:0] ptr_q;
  logic [SELW-1:0] ptr_d;
  logic [SELW-1:0] grant;
  logic            found;
  logic            free;
  logic            xfer;
  logic [XLEN-1:0] grant_data;
  logic [XLEN-1:0] out_data_q;
  logic [SELW-1:0] out_sel_q;
  logic            out_valid_q;
`ifdef RR_MUX_PKT_LOCK_EN
  logic            lock_q;
  logic [SELW-1:0] lock_sel_q;
`endif

  assign free = !out_valid_q || out_ready;

  // Scan from ptr with an explicit modulo-N wrap so non-power-of-two N stays in range.
  always_comb begin
    logic [SELW:0] idx;
    found = 1'b0;
    grant = '0;
    idx   = '0;
`ifdef RR_MUX_PKT_LOCK_EN
    if (lock_q) begin
      found = in_valid[lock_sel_q];
      grant = lock_sel_q;
    end else begin
`endif
      for (int i = 0; i < N; i++) begin
        idx = {1'b0, ptr_q} + (SELW+1)'(i);
        if (idx >= (SELW+1)'(N)) idx = idx - (SELW+1)'(N);
        if (!found && in_valid[idx[SELW-1:0]]) begin
          found = 1'b1;
          grant = idx[SELW-1:0];
        end
      end
`ifdef RR_MUX_PKT_LOCK_EN
    end
`endif
  end

  assign xfer = free && found;

  always_comb begin
    in_ready   = '0;
    grant_data = '0;
    for (int k = 0; k < N; k++) begin
      if (grant == SELW'(k)) begin
        grant_data = in_data[k*XLEN +: XLEN];
        if (rst_n && xfer) in_ready[k] = 1'b1;
      end
    end
  end

  assign ptr_d = (grant == SELW'(N-1)) ? '0 : grant + SELW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
`ifdef RR_MUX_PKT_LOCK_EN
      lock_q      <= 1'b0;
      lock_sel_q  <= '0;
`endif
    end else if (xfer) begin
      out_data_q  <= grant_data;
      out_sel_q   <= grant;
      out_valid_q <= 1'b1;
`ifdef RR_MUX_PKT_LOCK_EN
      // Mid-packet beats pin the grant and freeze ptr until the last beat.
      if (in_last[grant]) begin
        lock_q <= 1'b0;
        ptr_q  <= ptr_d;
      end else begin
        lock_q     <= 1'b1;
        lock_sel_q <= grant;
      end
`else
      ptr_q       <= ptr_d;
`endif
    end else if (free) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_mux_n_1.sv
// Directed bench for rr_mux_n_1: N=4 table of vectors plus N=3 wrap and packet-lock sequences.
module tb_rr_mux_n_1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [127:0] d4;
  logic [3:0]  v4 = '0;
  logic [3:0]  r4;
  logic [31:0] od4;
  logic [1:0]  os4;
  logic        ov4;
  logic        ordy4 = 1'b0;
  logic [95:0] d3;
  logic [2:0]  v3 = '0;
  logic [2:0]  r3;
  logic [31:0] od3;
  logic [1:0]  os3;
  logic        ov3;
  logic        ordy3 = 1'b0;
`ifdef RR_MUX_PKT_LOCK_EN
  logic [3:0]  l4 = 4'b1111;
  logic [2:0]  l3 = 3'b111;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign d4 = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
  assign d3 = {32'hB2, 32'hB1, 32'hB0};

  rr_mux_n_1 #(.XLEN(32), .N(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_data(d4), .in_valid(v4),
`ifdef RR_MUX_PKT_LOCK_EN
    .in_last(l4),
`endif
    .in_ready(r4), .out_data(od4), .out_sel(os4), .out_valid(ov4), .out_ready(ordy4));

  rr_mux_n_1 #(.XLEN(32), .N(3)) u3 (
    .clk(clk), .rst_n(rst_n), .in_data(d3), .in_valid(v3),
`ifdef RR_MUX_PKT_LOCK_EN
    .in_last(l3),
`endif
    .in_ready(r3), .out_data(od3), .out_sel(os3), .out_valid(ov3), .out_ready(ordy3));

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  typedef struct packed {
    logic        rst_n;
    logic [3:0]  vld;
    logic        ordy;
    logic [3:0]  rdy;
    logic        ov;
    logic [1:0]  sel;
    logic [31:0] data;
  } vec_t;

  vec_t tbl [22];

  // One N=4 step: drive at negedge, check in_ready before the edge, outputs after it.
  task automatic step4(input int idx, input vec_t t);
    @(negedge clk);
    rst_n = t.rst_n; v4 = t.vld; ordy4 = t.ordy;
    #1;
    chk("in_ready", idx, 32'(r4), 32'(t.rdy));
    @(posedge clk); #1;
    chk("out_valid", idx, 32'(ov4), 32'(t.ov));
    chk("out_sel", idx, 32'(os4), 32'(t.sel));
    chk("out_data", idx, od4, t.data);
  endtask

  task automatic step3(input int idx, input logic [2:0] vld, input logic [2:0] rdy,
                       input logic ov, input logic [1:0] sel, input logic [31:0] data);
    @(negedge clk);
    v3 = vld; ordy3 = 1'b1;
    #1;
    chk("n3_in_ready", idx, 32'(r3), 32'(rdy));
    @(posedge clk); #1;
    chk("n3_out_valid", idx, 32'(ov3), 32'(ov));
    chk("n3_out_sel", idx, 32'(os3), 32'(sel));
    chk("n3_out_data", idx, od3, data);
  endtask

  initial begin
    //            rst  vld     ordy rdy     ov   sel    data
    tbl[0]  = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h0};
    tbl[1]  = '{1'b1, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0};
    tbl[2]  = '{1'b1, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hA1};
    tbl[3]  = '{1'b1, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA2};
    tbl[4]  = '{1'b1, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hA3};
    tbl[5]  = '{1'b1, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0};
    tbl[6]  = '{1'b1, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hA1};
    tbl[7]  = '{1'b1, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA2};
    tbl[8]  = '{1'b1, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hA3};
    tbl[9]  = '{1'b1, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA2};
    tbl[10] = '{1'b1, 4'b1001, 1'b0, 4'b0000, 1'b1, 2'd2, 32'hA2};
    tbl[11] = '{1'b1, 4'b1001, 1'b0, 4'b0000, 1'b1, 2'd2, 32'hA2};
    tbl[12] = '{1'b1, 4'b1001, 1'b0, 4'b0000, 1'b1, 2'd2, 32'hA2};
    tbl[13] = '{1'b1, 4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hA3};
    tbl[14] = '{1'b1, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hA1};
    tbl[15] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 32'hA1};
    tbl[16] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 32'hA1};
    tbl[17] = '{1'b1, 4'b0111, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA2};
    tbl[18] = '{1'b1, 4'b0011, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0};
    tbl[19] = '{1'b1, 4'b0011, 1'b0, 4'b0000, 1'b1, 2'd0, 32'hA0};
    tbl[20] = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h0};
    tbl[21] = '{1'b1, 4'b1101, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0};

    for (int i = 0; i < 22; i++) step4(i, tbl[i]);
    @(negedge clk);
    v4 = '0;

    // N=3: lone channel 2 must wrap ptr to 0, then 0 and 1 are served in order.
    step3(100, 3'b100, 3'b100, 1'b1, 2'd2, 32'hB2);
    step3(101, 3'b100, 3'b100, 1'b1, 2'd2, 32'hB2);
    step3(102, 3'b100, 3'b100, 1'b1, 2'd2, 32'hB2);
    step3(103, 3'b011, 3'b001, 1'b1, 2'd0, 32'hB0);
    step3(104, 3'b011, 3'b010, 1'b1, 2'd1, 32'hB1);
    step3(105, 3'b011, 3'b001, 1'b1, 2'd0, 32'hB0);
    step3(106, 3'b000, 3'b000, 1'b0, 2'd0, 32'hB0);

`ifdef RR_MUX_PKT_LOCK_EN
    // Channel 1 sends a 3-beat packet while channel 0 stays valid; ptr=1 from the last table row.
    l4 = 4'b0000;
    step4(200, '{1'b1, 4'b0011, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hA1});
    step4(201, '{1'b1, 4'b0011, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hA1});
    step4(202, '{1'b1, 4'b0001, 1'b1, 4'b0000, 1'b0, 2'd1, 32'hA1});
    @(negedge clk);
    l4 = 4'b0010;
    step4(203, '{1'b1, 4'b0011, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hA1});
    step4(204, '{1'b1, 4'b0011, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0});
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
